// File: rtl/if_id_reg_pkg.sv
// Shared pipeline-register defaults: field widths and the bubble instruction encoding.
package if_id_reg_pkg;
  localparam int unsigned PC_W_DEF    = 8;
  localparam int unsigned INSTR_W_DEF = 8;
  // Kept wide so a pipeline register of any instruction width can cast it down.
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
endpackage

// File: rtl/pipe_reg_en_clr.sv
// Generic pipeline field register: synchronous reset and clear both load CLR_VAL,
// enable loads d, otherwise the field holds its value.
module pipe_reg_en_clr #(
  parameter int unsigned W = 8,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Priority is reset over clear over load; reset is tested first so X on clr/en cannot leak in.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= CLR_VAL;
    end else if (clr) begin
      q <= CLR_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: carries the fetched PC and instruction to decode,
// with stall (write_en=0) and bubble insertion (flush).
module if_id_reg
  import if_id_reg_pkg::*;
#(
  parameter int unsigned PC_W    = PC_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF[INSTR_W-1:0]
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               write_en,
  input  logic               flush,
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [PC_W-1:0]    pc_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               valid_out
);

  pipe_reg_en_clr #(
    .W       (PC_W),
    .CLR_VAL ({PC_W{1'b0}})
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .en  (write_en),
    .d   (pc),
    .q   (pc_out)
  );

  pipe_reg_en_clr #(
    .W       (INSTR_W),
    .CLR_VAL (NOP_INSTR)
  ) u_instr_reg (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .en  (write_en),
    .d   (instr_in),
    .q   (instr_out)
  );

  // A real load always marks the slot valid; reset and flush mark it as a bubble.
  pipe_reg_en_clr #(
    .W       (1),
    .CLR_VAL (1'b0)
  ) u_valid_reg (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .en  (write_en),
    .d   (1'b1),
    .q   (valid_out)
  );

endmodule

// File: tb/tb_if_id_reg.sv
// Directed self-checking bench for if_id_reg: reset, load, stall, flush and
// priority cases with hand-computed expected register contents.
module tb_if_id_reg;
  logic       clk;
  logic       rst;
  logic       write_en;
  logic       flush;
  logic [7:0] pc;
  logic [7:0] instr_in;
  logic [7:0] pc_out;
  logic [7:0] instr_out;
  logic       valid_out;

  int total;
  int bad;

  if_id_reg dut (
    .clk       (clk),
    .rst       (rst),
    .write_en  (write_en),
    .flush     (flush),
    .pc        (pc),
    .instr_in  (instr_in),
    .pc_out    (pc_out),
    .instr_out (instr_out),
    .valid_out (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect3(input string tag, input logic [7:0] e_pc, input logic [7:0] e_instr,
                         input logic e_valid);
    chk({tag, ".pc"}, pc_out, e_pc);
    chk({tag, ".instr"}, instr_out, e_instr);
    chk({tag, ".valid"}, {7'd0, valid_out}, {7'd0, e_valid});
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset with X on control and junk on data
    rst = 1'b1; write_en = 1'bx; flush = 1'bx; pc = 8'hFF; instr_in = 8'hEE;
    step();
    expect3("reset", 8'h00, 8'h00, 1'b0);

    // Release with no write keeps reset values
    rst = 1'b0; write_en = 1'b0; flush = 1'b0;
    step();
    expect3("release_hold", 8'h00, 8'h00, 1'b0);

    // First load
    write_en = 1'b1; pc = 8'h10; instr_in = 8'hA5;
    step();
    expect3("load1", 8'h10, 8'hA5, 1'b1);

    // Multi-cycle stall with changing inputs
    write_en = 1'b0; pc = 8'h20; instr_in = 8'h3C;
    step();
    expect3("stall1", 8'h10, 8'hA5, 1'b1);
    pc = 8'hC1; instr_in = 8'h5E;
    step();
    expect3("stall2", 8'h10, 8'hA5, 1'b1);
    pc = 8'h00; instr_in = 8'hFF;
    step();
    expect3("stall3", 8'h10, 8'hA5, 1'b1);

    // First write after stall loads current inputs
    write_en = 1'b1; pc = 8'h33; instr_in = 8'h55;
    step();
    expect3("load_after_stall", 8'h33, 8'h55, 1'b1);

    // Flush beats write_en
    flush = 1'b1; write_en = 1'b1; pc = 8'h44; instr_in = 8'h77;
    step();
    expect3("flush_over_write", 8'h00, 8'h00, 1'b0);

    // Write on the edge right after a flush, then back-to-back writes
    flush = 1'b0; write_en = 1'b1; pc = 8'h22; instr_in = 8'h99;
    step();
    expect3("load_after_flush", 8'h22, 8'h99, 1'b1);
    pc = 8'h23; instr_in = 8'h9A;
    step();
    expect3("b2b_1", 8'h23, 8'h9A, 1'b1);
    pc = 8'hFE; instr_in = 8'h81;
    step();
    expect3("b2b_2", 8'hFE, 8'h81, 1'b1);

    // Flush during a stall still inserts the bubble
    write_en = 1'b0; flush = 1'b1; pc = 8'h12; instr_in = 8'h34;
    step();
    expect3("flush_in_stall", 8'h00, 8'h00, 1'b0);

    // Stall after a flush keeps the bubble
    flush = 1'b0; write_en = 1'b0;
    step();
    expect3("stall_bubble", 8'h00, 8'h00, 1'b0);

    // Reset overrides a write on the same edge
    write_en = 1'b1; pc = 8'h5A; instr_in = 8'hC3;
    step();
    expect3("load_pre_rst", 8'h5A, 8'hC3, 1'b1);
    rst = 1'b1; write_en = 1'b1; pc = 8'h66; instr_in = 8'h11;
    step();
    expect3("rst_over_write", 8'h00, 8'h00, 1'b0);

    // Reset overrides a stall, then overrides a flush
    rst = 1'b0; write_en = 1'b1; pc = 8'h7F; instr_in = 8'h80;
    step();
    expect3("load_pre_rst2", 8'h7F, 8'h80, 1'b1);
    rst = 1'b1; write_en = 1'b0; flush = 1'b0;
    step();
    expect3("rst_in_stall", 8'h00, 8'h00, 1'b0);
    rst = 1'b1; write_en = 1'b1; flush = 1'b1; pc = 8'hAA; instr_in = 8'hBB;
    step();
    expect3("rst_held", 8'h00, 8'h00, 1'b0);

    rst = 1'b0; flush = 1'b0; write_en = 1'b1; pc = 8'h01; instr_in = 8'h02;
    step();
    expect3("final_load", 8'h01, 8'h02, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_reg.md
IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 Parameter: PC_W, default 8, width of the program-counter field.
REQ-002 Parameter: INSTR_W, default 8, width of the instruction field.
REQ-003 Parameter: NOP_INSTR, default 0, instruction encoding inserted on reset/flush.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  reset, synchronous, active-high.
REQ-006 Port: write_en  input  1  load enable; 0 = stall (hold contents).
REQ-007 Port: flush  input  1  bubble insert; replaces contents with NOP.
REQ-008 Port: pc  input  PC_W  PC of the fetched instruction.
REQ-009 Port: instr_in  input  INSTR_W  fetched instruction.
REQ-010 Port: pc_out  output  PC_W  registered PC to decode stage.
REQ-011 Port: instr_out  output  INSTR_W  registered instruction to decode stage.
REQ-012 Port: valid_out  output  1  1 = contents hold a real fetched instruction, 0 = bubble/NOP.

Function
REQ-013 The block SHALL be a single pipeline register between fetch and decode; one clock domain.
REQ-014 All outputs SHALL be driven directly from flops; no combinational path from any input to any output.
REQ-015 Update priority at each rising clk edge SHALL be: rst > flush > write_en > hold.
REQ-016 rst=1: pc_out<=0, instr_out<=NOP_INSTR, valid_out<=0, regardless of flush/write_en/data inputs.
REQ-017 rst=0, flush=1: pc_out<=0, instr_out<=NOP_INSTR, valid_out<=0, regardless of write_en.
REQ-018 rst=0, flush=0, write_en=1: pc_out<=pc, instr_out<=instr_in, valid_out<=1; latency exactly one edge.
REQ-019 rst=0, flush=0, write_en=0: all outputs SHALL hold previous values; input changes SHALL not propagate.
REQ-020 A stall of any length SHALL preserve contents bit-exactly; first write_en=1 edge after the stall loads the then-current inputs.
REQ-021 flush asserted during a stall (write_en=0) SHALL still insert the NOP.
REQ-022 Back-to-back writes SHALL load new values every edge with no dead cycle; write on the edge following a flush SHALL load normally.
REQ-023 Fields SHALL be stored unmodified: no arithmetic, truncation or extension of pc or instr_in.
REQ-024 X on write_en/flush while rst=1 SHALL not corrupt the reset value.

Reset
REQ-025 Reset SHALL be synchronous, active-high, sampled on rising clk; no asynchronous path.
REQ-026 Reset values: pc_out=0, instr_out=NOP_INSTR, valid_out=0; held for every edge rst=1.
REQ-027 Release of rst with write_en=0 SHALL keep reset values until the first qualifying write.
REQ-028 Reset asserted mid-operation (during stall or write) SHALL override on that same edge.

Structure
REQ-029 Shared package SHALL hold PC_W/INSTR_W defaults and the NOP_INSTR constant, reused by other pipeline registers.
REQ-030 One sub-module is natural: a generic enable/clear register (pipe_reg_en_clr) instantiated per field; a flat implementation is equally acceptable.

Verification
REQ-031 rst=1 one edge, inputs arbitrary -> pc_out=0x00, instr_out=0x00, valid_out=0; rst=0, write_en=0 one edge -> still 0x00/0x00.
REQ-032 write_en=1, flush=0, pc=0x10, instr_in=0xA5 -> after one edge pc_out=0x10, instr_out=0xA5, valid_out=1.
REQ-033 Then write_en=0, pc=0x20, instr_in=0x3C -> after edge outputs remain 0x10/0xA5.
REQ-034 write_en=1, pc=0x33, instr_in=0x55 -> 0x33/0x55; then flush=1, write_en=1, pc=0x44, instr_in=0x77 -> 0x00/0x00, valid_out=0.
REQ-035 flush=0, write_en=1, pc=0x22, instr_in=0x99 -> 0x22/0x99, valid_out=1; then rst=1 with write_en=1 -> 0x00/0x00.
